// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - opcode/response constants and parser state encoding for dbg_cmd_parser
package dbg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_SEND,
        ST_TX_ARM,
        ST_TX_WAIT
    } state_t;

endpackage

// File: rtl/dbg_byte_timer.sv
// rtl/dbg_byte_timer.sv - inter-byte idle counter: load clears, count_en advances, saturates at expiry
module dbg_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count_en && cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/dbg_cmd_parser.sv
// rtl/dbg_cmd_parser.sv - UART byte command parser driving the debug register bus; optional timeout via DBG_PARSER_TIMEOUT_EN
module dbg_cmd_parser
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter int          ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              received,
    input  logic [7:0]        rx_byte,
    input  logic              recv_error,
    input  logic              is_transmitting,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata
);

    // The timer counter width collapses to zero bits for a zero limit.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dbg_cmd_parser: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    logic   op_is_wr;
    logic   timeout_expired;

`ifdef DBG_PARSER_TIMEOUT_EN
    dbg_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (received),
        .count_en (state == ST_GET_ADDR || state == ST_GET_DATA),
        .expired  (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // Every entry into SEND pre-arms transmit from the current busy flag so
    // the registered pulse lands in the first SEND cycle when the UART is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_is_wr  <= 1'b0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
        end else begin
            transmit <= 1'b0;
            bus_we   <= 1'b0;
            bus_re   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (recv_error) begin
                        tx_byte  <= RSP_ERR;
                        transmit <= !is_transmitting;
                        state    <= ST_SEND;
                    end else if (received) begin
                        if (rx_byte == OP_WR || rx_byte == OP_RD) begin
                            op_is_wr <= (rx_byte == OP_WR);
                            state    <= ST_GET_ADDR;
                        end else begin
                            tx_byte  <= RSP_ERR;
                            transmit <= !is_transmitting;
                            state    <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (recv_error) begin
                        tx_byte  <= RSP_ERR;
                        transmit <= !is_transmitting;
                        state    <= ST_SEND;
                    end else if (received) begin
                        bus_addr <= rx_byte[ADDR_W-1:0];
                        bus_re   <= !op_is_wr;
                        state    <= op_is_wr ? ST_GET_DATA : ST_BUS_RD;
                    end else if (timeout_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    if (recv_error) begin
                        tx_byte  <= RSP_ERR;
                        transmit <= !is_transmitting;
                        state    <= ST_SEND;
                    end else if (received) begin
                        bus_wdata <= rx_byte;
                        bus_we    <= 1'b1;
                        state     <= ST_BUS_WR;
                    end else if (timeout_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUS_WR: begin
                    tx_byte  <= RSP_OK;
                    transmit <= !is_transmitting;
                    state    <= ST_SEND;
                end
                ST_BUS_RD: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    tx_byte  <= bus_rdata;
                    transmit <= !is_transmitting;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (transmit) begin
                        state <= ST_TX_ARM;
                    end else if (!is_transmitting) begin
                        transmit <= 1'b1;
                    end
                end
                ST_TX_ARM: begin
                    state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (!is_transmitting) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
